// File: rtl/layer3_mac_accum.sv
// rtl/layer3_mac_accum.sv - registered adder tree, windowed accumulator and requantiser for Layer3
// Sums NUM_IN products per beat, accumulates ACC_LEN beats plus bias, rounds and saturates.
module layer3_mac_accum #(
  parameter int NUM_IN     = 8,
  parameter int PROD_W     = 32,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8,
  parameter int ACC_LEN    = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*PROD_W-1:0] in_data,
  input  logic [OUT_W-1:0]         in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_sat
);

  localparam int L  = $clog2(NUM_IN);
  localparam int SW = PROD_W + L;
  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_LEN - 1);
  localparam logic signed [ACC_W-1:0] MAXV = (ACC_W'(1) << (OUT_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_SHIFT - 1);

  logic en;
  logic accept;
  logic [CW-1:0] cnt;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Side-band pipe: index 0 lines up with the leaf registers, index L with the tree root.
  logic [L:0]       vp;
  logic [L:0]       fp;
  logic [L:0]       lp;
  logic [OUT_W-1:0] bp [L+1];

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      vp <= '0;
    end else if (en) begin
      vp[0] <= accept;
      for (int i = 1; i <= L; i++) vp[i] <= vp[i-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (en) begin
      fp[0] <= (cnt == '0);
      lp[0] <= (cnt == CNT_LAST);
      bp[0] <= in_bias;
      for (int i = 1; i <= L; i++) begin
        fp[i] <= fp[i-1];
        lp[i] <= lp[i-1];
        bp[i] <= bp[i-1];
      end
    end
  end

  logic signed [SW-1:0] leaf [NUM_IN];
  logic signed [SW-1:0] node [1:NUM_IN-1];

  always_ff @(posedge ap_clk) begin
    if (en) begin
      for (int i = 0; i < NUM_IN; i++)
        leaf[i] <= {{L{in_data[i*PROD_W+PROD_W-1]}}, in_data[i*PROD_W +: PROD_W]};
    end
  end

  // Heap-ordered tree: node n sums children 2n and 2n+1; indices >= NUM_IN are leaves.
  for (genvar n = 1; n < NUM_IN; n++) begin : g_node
    if (2 * n >= NUM_IN) begin : g_bottom
      always_ff @(posedge ap_clk) begin
        if (en) node[n] <= leaf[2*n-NUM_IN] + leaf[2*n+1-NUM_IN];
      end
    end else begin : g_inner
      always_ff @(posedge ap_clk) begin
        if (en) node[n] <= node[2*n] + node[2*n+1];
      end
    end
  end

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] tree_ext;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] rnd;
  logic                    sat_hi;
  logic                    sat_lo;

  always_comb begin
    bias_ext = {{(ACC_W-OUT_W){bp[L][OUT_W-1]}}, bp[L]} << FRAC_SHIFT;
    tree_ext = {{(ACC_W-SW){node[1][SW-1]}}, node[1]};
    base     = fp[L] ? bias_ext : acc;
    sum      = base + tree_ext;
    rnd      = (sum + HALF) >>> FRAC_SHIFT;
    sat_hi   = rnd > MAXV;
    sat_lo   = rnd < MINV;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      out_valid <= vp[L] && lp[L];
      if (vp[L]) begin
        if (lp[L]) begin
          acc      <= '0;
          out_data <= sat_hi ? MAXV[OUT_W-1:0] : (sat_lo ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0]);
          out_sat  <= sat_hi || sat_lo;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer3_mac_accum.sv
// tb/tb_layer3_mac_accum.sv - self-checking bench for layer3_mac_accum
// Directed vector table, stall/reset sequences and random traffic against a group-sum model.
module tb_layer3_mac_accum;
  localparam int NUM_IN = 8, PROD_W = 32, ACC_W = 40, OUT_W = 16, FRAC_SHIFT = 8, ACC_LEN = 4;
  localparam int DW = NUM_IN * PROD_W;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DW-1:0] in_data = '0;
  logic [OUT_W-1:0] in_bias = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic out_sat;

  always #5 ap_clk = ~ap_clk;

  layer3_mac_accum #(
    .NUM_IN(NUM_IN), .PROD_W(PROD_W), .ACC_W(ACC_W), .OUT_W(OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT), .ACC_LEN(ACC_LEN)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_bias(in_bias), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat)
  );

  int nchk = 0;
  int nfail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: whole-group arithmetic on accepted beats.
  typedef struct { int d; bit sat; } res_t;
  res_t   expq[$];
  int     obsq[$];
  longint m_sum = 0;
  int     m_cnt = 0;

  always @(negedge ap_clk) begin
    longint r;
    res_t e;
    if (ap_rst) begin
      m_cnt = 0;
      m_sum = 0;
    end else begin
      if (out_valid && out_ready) begin
        obsq.push_back(int'($signed(out_data)));
        if (expq.size() == 0) begin
          check("mon_unexpected_output", 1, 0);
        end else begin
          e = expq.pop_front();
          check("mon_data", $signed(out_data), e.d);
          check("mon_sat", out_sat, e.sat);
        end
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) m_sum = longint'($signed(in_bias)) * (64'sd1 << FRAC_SHIFT);
        for (int i = 0; i < NUM_IN; i++) m_sum += longint'($signed(in_data[i*PROD_W +: PROD_W]));
        m_cnt++;
        if (m_cnt == ACC_LEN) begin
          r = (m_sum + (64'sd1 << (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
          if (r > 32767) begin e.d = 32767; e.sat = 1'b1; end
          else if (r < -32768) begin e.d = -32768; e.sat = 1'b1; end
          else begin e.d = int'(r); e.sat = 1'b0; end
          expq.push_back(e);
          m_cnt = 0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] pack(input int a, input int b);
    logic [DW-1:0] d;
    d[PROD_W-1:0] = a;
    for (int i = 1; i < NUM_IN; i++) d[i*PROD_W +: PROD_W] = b;
    return d;
  endfunction

  function automatic logic [DW-1:0] rand_data(input int mode);
    logic [DW-1:0] d;
    int v;
    for (int i = 0; i < NUM_IN; i++) begin
      case (mode)
        0:       v = int'($urandom_range(0, 4000)) - 2000;
        1:       v = int'($urandom);
        default: v = int'($urandom_range(0, 2097152)) - 1048576;
      endcase
      d[i*PROD_W +: PROD_W] = v;
    end
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d, input int bias);
    int g;
    in_valid = 1'b1;
    in_data  = d;
    in_bias  = OUT_W'(bias);
    g = 0;
    @(negedge ap_clk);
    while (!in_ready && g < 200) begin
      @(negedge ap_clk);
      g++;
    end
    if (g >= 200) begin
      nchk++;
      nfail++;
      $display("FAIL send_wait: in_ready low for %0d cycles, expected accept within 200", g);
    end
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
  endtask

  typedef struct { string name; int a; int b; int c; int bf; int br; int ed; bit es; } vec_t;
  vec_t vt[$];

  initial begin
    int lat;
    int n;
    bit done;

    vt.push_back('{"t1_all256",     256, 256, 256, 0, 0, 32, 1'b0});
    vt.push_back('{"t2_rnd384",     384, 0, 0, 0, 0, 2, 1'b0});
    vt.push_back('{"t2_rndm384",   -384, 0, 0, 0, 0, -1, 1'b0});
    vt.push_back('{"t2_rnd383",     383, 0, 0, 0, 0, 1, 1'b0});
    vt.push_back('{"t3_sat_pos",    1073741824, 1073741824, 1073741824, 0, 0, 32767, 1'b1});
    vt.push_back('{"t3_sat_neg",   -1073741824, -1073741824, -1073741824, 0, 0, -32768, 1'b1});
    vt.push_back('{"t4_bias",       0, 0, 0, -5, -5, -5, 1'b0});
    vt.push_back('{"t4_bias_later", 0, 0, 0, -5, 7, -5, 1'b0});
    vt.push_back('{"max_exact",     8388352, 0, 0, 0, 0, 32767, 1'b0});
    vt.push_back('{"max_round_up",  8388480, 0, 0, 0, 0, 32767, 1'b1});
    vt.push_back('{"min_exact",    -8388608, 0, 0, 0, 0, -32768, 1'b0});

    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      for (int b = 0; b < ACC_LEN; b++)
        send((b == 0) ? pack(vt[i].a, vt[i].b) : pack(vt[i].c, vt[i].c), (b == 0) ? vt[i].bf : vt[i].br);
      wait_out(lat);
      check({vt[i].name, "_latency"}, lat, 4);
      check({vt[i].name, "_data"}, $signed(out_data), vt[i].ed);
      check({vt[i].name, "_sat"}, out_sat, vt[i].es);
      @(posedge ap_clk);
      #1;
      check({vt[i].name, "_valid_one_cycle"}, out_valid, 0);
    end

    // Three groups back to back with a 10-cycle consumer stall after the first result.
    obsq.delete();
    fork
      begin
        for (int g = 0; g < 3; g++)
          for (int b = 0; b < ACC_LEN; b++) send(pack((g + 1) * 256, (g + 1) * 256), 0);
      end
      begin
        n = 0;
        while (!out_valid && n < 100) begin
          @(posedge ap_clk);
          #1;
          n++;
        end
        out_ready = 1'b0;
        repeat (10) begin
          @(posedge ap_clk);
          #1;
          check("stall_in_ready", in_ready, 0);
          check("stall_out_data_hold", $signed(out_data), 32);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (obsq.size() < 3 && n < 50) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    check("stall_result_count", obsq.size(), 3);
    if (obsq.size() == 3) begin
      check("stall_res0", obsq[0], 32);
      check("stall_res1", obsq[1], 64);
      check("stall_res2", obsq[2], 96);
    end

    // Reset in the middle of a group discards the partial sum.
    send(pack(1000, 1000), 3);
    send(pack(1000, 1000), 3);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    ap_rst = 1'b0;
    for (int b = 0; b < ACC_LEN; b++) send(pack(256, 256), 0);
    wait_out(lat);
    check("midrst_latency", lat, 4);
    check("midrst_data", $signed(out_data), 32);
    @(posedge ap_clk);
    #1;

    // Random traffic with bubbles and random backpressure.
    done = 1'b0;
    fork
      begin
        for (int g = 0; g < 16; g++) begin
          int mode;
          int bias;
          mode = int'($urandom_range(0, 2));
          bias = int'($urandom_range(0, 65535)) - 32768;
          for (int b = 0; b < ACC_LEN; b++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge ap_clk);
              #1;
            end
            send(rand_data(mode), (b == 0) ? bias : int'($urandom_range(0, 100)));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk);
          #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    n = 0;
    while (expq.size() != 0 && n < 300) begin
      @(posedge ap_clk);
      n++;
    end
    check("drain_pending_results", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
